mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
//
// Holds one instruction. It aligns and extends load data returned by the data
// SRAM, and forwards the write-back bundle to WB and the bypass bundle to ID.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   reset            : synchronous active-high reset
//   flush            : exception/ertn flush from WB, kills the held instruction
//   exe_to_mem_valid : EXE presents an instruction
//   mem_allowin      : this stage can accept an instruction this cycle
//   exe_to_mem_zip   : 204-bit EXE bundle (see unpack below, MSB first)
//   data_sram_rdata  : load word for the access EXE issued last cycle
//   wb_allowin       : WB can accept an instruction this cycle
//   mem_to_wb_valid  : this stage presents an instruction to WB
//   mem_to_wb_zip    : 199-bit WB bundle
//   mem_rf_zip       : {csr_read, rf_we, rf_waddr, final_result} bypass to ID
//   mem_ex           : held instruction carries an exception or ertn
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         exe_to_mem_valid,
  output logic         mem_allowin,
  input  logic [203:0] exe_to_mem_zip,
  input  logic [31:0]  data_sram_rdata,
  input  logic         wb_allowin,
  output logic         mem_to_wb_valid,
  output logic [198:0] mem_to_wb_zip,
  output logic [38:0]  mem_rf_zip,
  output logic         mem_ex
);

  logic         mem_valid_reg;
  logic         first_cycle_reg;
  logic [31:0]  rdata_buf_reg;
  logic [203:0] zip_reg;

  // Latched instruction fields
  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] result;
  logic [3:0]  mem_op;
  logic [31:0] pc;
  logic        csr_read;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] vaddr;
  logic        ex_valid;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic        is_ertn;

  assign {res_from_mem, rf_we, rf_waddr, result, mem_op, pc,
          csr_read, csr_we, csr_num, csr_wmask, csr_wvalue, vaddr,
          ex_valid, ecode, esubcode, is_ertn} = zip_reg;

  // mem_op[2] carries no meaning for loads in this stage
  logic unused_mem_op;
  assign unused_mem_op = mem_op[2];

  logic accept;

  // ready_go is always 1, so the stage frees up whenever WB takes its
  // instruction. Allowin is also forced high during reset: the stage is being
  // emptied anyway and anything offered in that cycle is discarded.
  assign mem_allowin     = reset | ~mem_valid_reg | wb_allowin;
  assign mem_to_wb_valid = mem_valid_reg;
  assign accept          = exe_to_mem_valid & mem_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_reg   <= 1'b0;
      first_cycle_reg <= 1'b0;
      rdata_buf_reg   <= 32'd0;
    end else begin
      if (flush)
        mem_valid_reg <= 1'b0;
      else if (mem_allowin)
        mem_valid_reg <= exe_to_mem_valid;
      first_cycle_reg <= accept;
      // The SRAM word is only valid in the first cycle; keep a copy so a WB
      // stall does not see the SRAM output drift to a later access.
      if (mem_valid_reg & first_cycle_reg)
        rdata_buf_reg <= data_sram_rdata;
    end
  end

  // Datapath register, no reset needed: it is qualified by mem_valid_reg.
  always_ff @(posedge clk) begin
    if (accept)
      zip_reg <= exe_to_mem_zip;
  end

  // Load alignment and extension
  logic [31:0] load_word;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] final_result;

  assign load_word = first_cycle_reg ? data_sram_rdata : rdata_buf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = load_word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[vaddr[1:0]];
  assign half_sel = vaddr[1] ? load_word[31:16] : load_word[15:0];

  // mem_op[3] set means zero-extend, so the fill bit is the sign bit only
  // when mem_op[3] is clear.
  always_comb begin
    load_ext = load_word;
    case (mem_op[1:0])
      2'd0:    load_ext = {{24{~mem_op[3] & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{~mem_op[3] & half_sel[15]}}, half_sel};
      default: load_ext = load_word;
    endcase
  end

  assign final_result = res_from_mem ? load_ext : result;

  assign mem_to_wb_zip = {rf_we, rf_waddr, final_result, pc,
                          csr_read, csr_we, csr_num, csr_wmask, csr_wvalue,
                          vaddr, ex_valid, ecode, esubcode, is_ertn};

  assign mem_rf_zip = {mem_valid_reg & csr_read, mem_valid_reg & rf_we,
                       rf_waddr, final_result};

  assign mem_ex = mem_valid_reg & (ex_valid | is_ertn);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [3:0]  mem_op;
    logic [31:0] pc;
    logic        csr_read;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] vaddr;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } in_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        csr_read;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] vaddr;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } out_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         exe_valid;
  logic         mem_allowin;
  in_t          zip;
  logic [31:0]  rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [198:0] wb_zip;
  logic [38:0]  mem_rf_zip;
  logic         mem_ex;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .exe_to_mem_valid (exe_valid),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_zip   (zip),
    .data_sram_rdata  (rdata),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_zip    (wb_zip),
    .mem_rf_zip       (mem_rf_zip),
    .mem_ex           (mem_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic started = 1'b0;

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkw(string name, logic [198:0] act, logic [198:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Load result from the architectural rules: pick the addressed byte/half
  // arithmetically and sign-extend by subtracting the range.
  function automatic logic [31:0] load_value(logic [3:0] op, logic [31:0] va,
                                             logic [31:0] w);
    int unsigned b;
    int v;
    case (op[1:0])
      2'd0: begin
        b = (w >> (8 * va[1:0])) & 32'hFF;
        v = (!op[3] && b >= 128) ? int'(b) - 256 : int'(b);
      end
      2'd1: begin
        b = (w >> (16 * va[1])) & 32'hFFFF;
        v = (!op[3] && b >= 32768) ? int'(b) - 65536 : int'(b);
      end
      default: v = int'(w);
    endcase
    return v;
  endfunction

  function automatic in_t mk(logic rfm, logic we, logic [4:0] wa,
                             logic [31:0] res, logic [3:0] op, logic [31:0] va,
                             logic ex, logic [5:0] ec, logic cr);
    in_t z;
    z.res_from_mem = rfm;
    z.rf_we        = we;
    z.rf_waddr     = wa;
    z.result       = res;
    z.mem_op       = op;
    z.pc           = 32'h1c00_0000 + va;
    z.csr_read     = cr;
    z.csr_we       = ~cr;
    z.csr_num      = 14'h0a5;
    z.csr_wmask    = 32'hF0F0_0F0F;
    z.csr_wvalue   = ~va;
    z.vaddr        = va;
    z.ex_valid     = ex;
    z.ecode        = ec;
    z.esubcode     = ex ? 9'h001 : 9'h000;
    z.is_ertn      = 1'b0;
    return z;
  endfunction

  // Reference model of the stage occupancy: one slot, filled when EXE offers
  // and the slot is free or draining, emptied by flush or reset.
  logic        m_valid = 1'b0;
  logic        m_first = 1'b0;
  in_t         m_zip;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_first <= 1'b0;
    end else begin
      if (exe_valid && (!m_valid || wb_allowin)) begin
        m_zip   <= zip;
        m_first <= 1'b1;
      end else begin
        m_first <= 1'b0;
      end
      if (flush)
        m_valid <= 1'b0;
      else if (!m_valid || wb_allowin)
        m_valid <= exe_valid;
    end
  end

  // Compare process: every cycle at the falling edge
  always @(negedge clk) begin
    out_t e;
    out_t a;
    if (started) begin
      // the load word is whatever the SRAM showed in the first held cycle
      if (m_valid && m_first)
        m_word = rdata;
      chk1("allowin", mem_allowin, reset | ~m_valid | wb_allowin);
      chk1("wb_valid", mem_to_wb_valid, m_valid);
      chk1("mem_ex", mem_ex, m_valid & (m_zip.ex_valid | m_zip.is_ertn));
      chk32("rf_en", {30'd0, mem_rf_zip[38:37]},
            {30'd0, m_valid & m_zip.csr_read, m_valid & m_zip.rf_we});
      if (m_valid) begin
        e.rf_we        = m_zip.rf_we;
        e.rf_waddr     = m_zip.rf_waddr;
        e.final_result = m_zip.res_from_mem ?
                         load_value(m_zip.mem_op, m_zip.vaddr, m_word) : m_zip.result;
        e.pc           = m_zip.pc;
        e.csr_read     = m_zip.csr_read;
        e.csr_we       = m_zip.csr_we;
        e.csr_num      = m_zip.csr_num;
        e.csr_wmask    = m_zip.csr_wmask;
        e.csr_wvalue   = m_zip.csr_wvalue;
        e.vaddr        = m_zip.vaddr;
        e.ex_valid     = m_zip.ex_valid;
        e.ecode        = m_zip.ecode;
        e.esubcode     = m_zip.esubcode;
        e.is_ertn      = m_zip.is_ertn;
        a = wb_zip;
        if (m_zip.ex_valid) begin
          // result is don't-care for an excepting instruction
          e.final_result = 32'd0;
          a.final_result = 32'd0;
        end else begin
          chk32("rf_result", mem_rf_zip[31:0], e.final_result);
        end
        chk32("rf_waddr", {27'd0, mem_rf_zip[36:32]}, {27'd0, e.rf_waddr});
        chkw("wb_zip", a, e);
      end
    end
  end

  // Offer z for one cycle, then present rd as the SRAM word and set WB
  // readiness for the held cycles; returns at the first held falling edge.
  task automatic send(string tag, in_t z, logic [31:0] rd, logic wb_after);
    @(posedge clk);
    #1;
    exe_valid = 1'b1;
    zip       = z;
    @(posedge clk);
    #1;
    exe_valid  = 1'b0;
    rdata      = rd;
    wb_allowin = wb_after;
    @(negedge clk);
    $display("txn %s op=%h vaddr=%h rdata=%h -> wb_valid=%b result=%h",
             tag, z.mem_op, z.vaddr, rd, mem_to_wb_valid, mem_rf_zip[31:0]);
  endtask

  logic [3:0] ops [6];
  out_t       o;

  initial begin
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2;
    ops[3] = 4'd8; ops[4] = 4'd9; ops[5] = 4'd2;
    reset      = 1'b1;
    flush      = 1'b0;
    exe_valid  = 1'b0;
    zip        = '0;
    rdata      = 32'd0;
    wb_allowin = 1'b0;

    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    chk1("rst_allowin", mem_allowin, 1'b1);
    chk1("rst_wb_valid", mem_to_wb_valid, 1'b0);
    chk1("rst_mem_ex", mem_ex, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst_allowin", mem_allowin, 1'b1);
    wb_allowin = 1'b1;

    // byte and half loads, signed and unsigned
    send("ld.b", mk(1, 1, 5'd3, 32'd0, 4'd0, 32'h1003, 0, 6'd0, 0), 32'h80FF_1234, 1'b1);
    chk32("ld_b", mem_rf_zip[31:0], 32'hFFFF_FF80);
    send("ld.bu", mk(1, 1, 5'd3, 32'd0, 4'd8, 32'h1003, 0, 6'd0, 0), 32'h80FF_1234, 1'b1);
    chk32("ld_bu", mem_rf_zip[31:0], 32'h0000_0080);
    send("ld.h", mk(1, 1, 5'd4, 32'd0, 4'd1, 32'h2002, 0, 6'd0, 0), 32'h9ABC_0000, 1'b1);
    chk32("ld_h", mem_rf_zip[31:0], 32'hFFFF_9ABC);
    send("ld.hu", mk(1, 1, 5'd4, 32'd0, 4'd9, 32'h2002, 0, 6'd0, 0), 32'h9ABC_0000, 1'b1);
    chk32("ld_hu", mem_rf_zip[31:0], 32'h0000_9ABC);

    // word load held by a WB stall while the SRAM output moves on
    send("ld.w", mk(1, 1, 5'd6, 32'd0, 4'd2, 32'h2000, 0, 6'd0, 0), 32'h1122_3344, 1'b0);
    chk32("ld_w_first", mem_rf_zip[31:0], 32'h1122_3344);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk32("ld_w_stall", mem_rf_zip[31:0], 32'h1122_3344);
      chk1("ld_w_stall_valid", mem_to_wb_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    wb_allowin = 1'b1;

    // non-load forwarding
    send("alu", mk(0, 1, 5'd5, 32'h1234, 4'd0, 32'h40, 0, 6'd0, 0), 32'hFFFF_FFFF, 1'b1);
    chk32("alu_rf_lo", mem_rf_zip[31:0], 32'h0000_1234);
    chk32("alu_rf_hi", {25'd0, mem_rf_zip[38:32]}, {25'd0, 1'b0, 1'b1, 5'd5});
    chk1("alu_wb_valid", mem_to_wb_valid, 1'b1);

    // exception pass-through
    send("exc", mk(0, 0, 5'd0, 32'hAAAA, 4'd0, 32'h55, 1, 6'h09, 0), 32'd0, 1'b1);
    chk1("exc_mem_ex", mem_ex, 1'b1);
    o = wb_zip;
    chk32("exc_ecode", {26'd0, o.ecode}, 32'h0000_0009);

    // flush wins over a simultaneous accept
    @(posedge clk);
    #1;
    exe_valid = 1'b1;
    zip       = mk(0, 1, 5'd7, 32'h77, 4'd0, 32'h70, 0, 6'd0, 0);
    flush     = 1'b1;
    @(posedge clk);
    #1;
    exe_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    $display("txn flush -> wb_valid=%b", mem_to_wb_valid);
    chk1("flush_valid", mem_to_wb_valid, 1'b0);

    // back-to-back stream with intermittent WB stalls
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      exe_valid  = 1'b1;
      zip        = mk(1, 1, i[4:0], 32'd0, ops[i % 6], 32'h3000 + i, 0, 6'd0, (i % 4) == 3);
      rdata      = 32'h8100_7F80 ^ (i * 32'h0101_0101);
      wb_allowin = (i % 4) != 2;
      @(negedge clk);
      $display("txn stream%0d wb_valid=%b result=%h", i, mem_to_wb_valid, mem_rf_zip[31:0]);
    end
    @(posedge clk);
    #1;
    exe_valid  = 1'b0;
    wb_allowin = 1'b1;
    repeat (2) @(posedge clk);

    // reset in the middle of a WB stall
    send("ld.w_rst", mk(1, 1, 5'd8, 32'd0, 4'd2, 32'h2004, 0, 6'd0, 0), 32'h5555_AAAA, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_stall_allowin", mem_allowin, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    $display("txn reset_mid_stall -> wb_valid=%b allowin=%b", mem_to_wb_valid, mem_allowin);
    chk1("rst_stall_valid", mem_to_wb_valid, 1'b0);
    chk1("rst_stall_allowin_after", mem_allowin, 1'b1);
    @(posedge clk);
    #1;
    wb_allowin = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
